// File: rtl/fa_selftest_checker_if.sv
// Link between the full-adder self-test checker and the adder under test:
// operands flow out of the checker, sum/carry flow back.
interface fa_selftest_checker_if;
    logic a;
    logic b;
    logic cin;
    logic dut_sum;
    logic dut_cout;

    modport master (
        output a,
        output b,
        output cin,
        input  dut_sum,
        input  dut_cout
    );

    modport slave (
        input  a,
        input  b,
        input  cin,
        output dut_sum,
        output dut_cout
    );
endinterface

// File: rtl/fa_selftest_checker.sv
// On-board self-test for a full adder: sweeps all 8 operand vectors, compares against a golden model.
// Optional first-failure capture outputs are enabled by defining FA_SELFTEST_FIRSTFAIL_EN.
module fa_selftest_checker #(
    parameter int unsigned SETTLE_CYCLES = 32'd2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_i,
    fa_selftest_checker_if.master       dut_if,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        pass_o,
    output logic [3:0]                  err_count_o,
    output logic [7:0]                  fail_vec_o
`ifdef FA_SELFTEST_FIRSTFAIL_EN
    ,
    output logic                        first_fail_valid_o,
    output logic [2:0]                  first_fail_idx_o,
    output logic [1:0]                  first_fail_obs_o
`endif
);

    if ((SETTLE_CYCLES < 32'd1) || (SETTLE_CYCLES > 32'd15)) begin : g_bad_settle
        $error("fa_selftest_checker: SETTLE_CYCLES must be in 1..15");
    end

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [3:0] SETTLE_RELOAD = 4'(SETTLE_CYCLES - 32'd1);

    // Reference full adder; result packed as {sum, cout}.
    function automatic logic [1:0] fa_golden(input logic [2:0] abc);
        logic s_v;
        logic c_v;
        s_v = abc[2] ^ abc[1] ^ abc[0];
        c_v = (abc[2] & abc[1]) | (abc[2] & abc[0]) | (abc[1] & abc[0]);
        return {s_v, c_v};
    endfunction

    logic [1:0] state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] wait_q, wait_d;
    logic [3:0] err_q, err_d;
    logic [7:0] fail_q, fail_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;

    logic [1:0] obs_s;
    logic [1:0] exp_s;
    logic       mismatch_s;
    logic       sweep_start_s;

    assign obs_s         = {dut_if.dut_sum, dut_if.dut_cout};
    assign exp_s         = fa_golden(idx_q);
    assign mismatch_s    = (obs_s != exp_s);
    assign sweep_start_s = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start_i;

    // Next-state and result update logic for the sweep FSM.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        err_d   = err_q;
        fail_d  = fail_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d = ST_SETTLE;
                    idx_d   = 3'd0;
                    wait_d  = SETTLE_RELOAD;
                    err_d   = 4'd0;
                    fail_d  = 8'd0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_SETTLE: begin
                if (wait_q == 4'd0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            ST_SAMPLE: begin
                if (mismatch_s) begin
                    fail_d[idx_q] = 1'b1;
                    err_d         = err_q + 4'd1;
                end else begin
                    err_d = err_q;
                end
                if (idx_q == 3'd7) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    wait_d  = SETTLE_RELOAD;
                    state_d = ST_SETTLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
        // done rises one cycle after entering DONE and drops as soon as a restart is accepted.
        done_d = (state_q == ST_DONE) && !start_i;
        pass_d = done_d && (err_q == 4'd0);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
            wait_q  <= 4'd0;
            err_q   <= 4'd0;
            fail_q  <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign dut_if.a    = idx_q[2];
    assign dut_if.b    = idx_q[1];
    assign dut_if.cin  = idx_q[0];
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign err_count_o = err_q;
    assign fail_vec_o  = fail_q;

`ifdef FA_SELFTEST_FIRSTFAIL_EN
    logic       ff_valid_q, ff_valid_d;
    logic [2:0] ff_idx_q, ff_idx_d;
    logic [1:0] ff_obs_q, ff_obs_d;

    // Capture only the first mismatch of each sweep.
    always_comb begin
        ff_valid_d = ff_valid_q;
        ff_idx_d   = ff_idx_q;
        ff_obs_d   = ff_obs_q;
        if (sweep_start_s) begin
            ff_valid_d = 1'b0;
            ff_idx_d   = 3'd0;
            ff_obs_d   = 2'd0;
        end else if ((state_q == ST_SAMPLE) && mismatch_s && !ff_valid_q) begin
            ff_valid_d = 1'b1;
            ff_idx_d   = idx_q;
            ff_obs_d   = obs_s;
        end else begin
            ff_valid_d = ff_valid_q;
        end
    end

    // First-failure registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ff_valid_q <= 1'b0;
            ff_idx_q   <= 3'd0;
            ff_obs_q   <= 2'd0;
        end else begin
            ff_valid_q <= ff_valid_d;
            ff_idx_q   <= ff_idx_d;
            ff_obs_q   <= ff_obs_d;
        end
    end

    assign first_fail_valid_o = ff_valid_q;
    assign first_fail_idx_o   = ff_idx_q;
    assign first_fail_obs_o   = ff_obs_q;
`else
    logic unused_s;
    assign unused_s = sweep_start_s;
`endif

endmodule

// File: tb/tb_fa_selftest_checker.sv
// Directed bench for fa_selftest_checker: a behavioural adder with injectable faults,
// plus a second instance built with SETTLE_CYCLES=1.
module tb_fa_selftest_checker;
    logic       clk;
    logic       rst;
    logic       start;
    logic       start1;
    logic       busy, done, pass;
    logic [3:0] err_count;
    logic [7:0] fail_vec;
    logic       busy1, done1, pass1;
    logic [3:0] err_count1;
    logic [7:0] fail_vec1;
    int         fault_mode;
    int         total;
    int         bad;

`ifdef FA_SELFTEST_FIRSTFAIL_EN
    logic       ff_valid, ff_valid1;
    logic [2:0] ff_idx, ff_idx1;
    logic [1:0] ff_obs, ff_obs1;
`endif

    fa_selftest_checker_if bus0 ();
    fa_selftest_checker_if bus1 ();

    // Adder under test: 0 = correct, 1 = cout stuck at 0, 2 = sum inverted.
    logic ref_sum0, ref_cout0;
    assign ref_sum0      = bus0.a ^ bus0.b ^ bus0.cin;
    assign ref_cout0     = (bus0.a & bus0.b) | (bus0.a & bus0.cin) | (bus0.b & bus0.cin);
    assign bus0.dut_sum  = (fault_mode == 2) ? ~ref_sum0 : ref_sum0;
    assign bus0.dut_cout = (fault_mode == 1) ? 1'b0 : ref_cout0;
    assign bus1.dut_sum  = bus1.a ^ bus1.b ^ bus1.cin;
    assign bus1.dut_cout = (bus1.a & bus1.b) | (bus1.a & bus1.cin) | (bus1.b & bus1.cin);

    fa_selftest_checker #(.SETTLE_CYCLES(32'd2)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .dut_if      (bus0),
        .busy_o      (busy),
        .done_o      (done),
        .pass_o      (pass),
        .err_count_o (err_count),
        .fail_vec_o  (fail_vec)
`ifdef FA_SELFTEST_FIRSTFAIL_EN
        ,
        .first_fail_valid_o (ff_valid),
        .first_fail_idx_o   (ff_idx),
        .first_fail_obs_o   (ff_obs)
`endif
    );

    fa_selftest_checker #(.SETTLE_CYCLES(32'd1)) u_dut1 (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start1),
        .dut_if      (bus1),
        .busy_o      (busy1),
        .done_o      (done1),
        .pass_o      (pass1),
        .err_count_o (err_count1),
        .fail_vec_o  (fail_vec1)
`ifdef FA_SELFTEST_FIRSTFAIL_EN
        ,
        .first_fail_valid_o (ff_valid1),
        .first_fail_idx_o   (ff_idx1),
        .first_fail_obs_o   (ff_obs1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One sweep on u_dut; optionally pulses start again at cycle 'poke' after launch.
    task automatic sweep(input int poke, input logic [7:0] exp_fail, input logic [3:0] exp_err);
        int exp_idx;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("launch_abc", {29'd0, bus0.a, bus0.b, bus0.cin}, 32'd0);
        check_eq("launch_busy", {31'd0, busy}, 32'd1);
        check_eq("launch_done", {31'd0, done}, 32'd0);
        check_eq("launch_fail_clr", {24'd0, fail_vec}, 32'd0);
        check_eq("launch_err_clr", {28'd0, err_count}, 32'd0);
        for (int i = 1; i <= 25; i++) begin
            start = (i == poke) ? 1'b1 : 1'b0;
            tick();
            exp_idx = (i / 3 > 7) ? 7 : i / 3;
            check_eq("step_abc", {29'd0, bus0.a, bus0.b, bus0.cin}, 32'(exp_idx));
            check_eq("step_busy", {31'd0, busy}, (i < 24) ? 32'd1 : 32'd0);
            check_eq("step_done", {31'd0, done}, (i == 25) ? 32'd1 : 32'd0);
        end
        start = 1'b0;
        check_eq("end_pass", {31'd0, pass}, (exp_err == 4'd0) ? 32'd1 : 32'd0);
        check_eq("end_err", {28'd0, err_count}, {28'd0, exp_err});
        check_eq("end_fail_vec", {24'd0, fail_vec}, {24'd0, exp_fail});
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        fault_mode = 0;
        rst        = 1'b1;
        start      = 1'b0;
        start1     = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_pass", {31'd0, pass}, 32'd0);
        check_eq("rst_err", {28'd0, err_count}, 32'd0);
        check_eq("rst_fail", {24'd0, fail_vec}, 32'd0);
        check_eq("rst_abc", {29'd0, bus0.a, bus0.b, bus0.cin}, 32'd0);
`ifdef FA_SELFTEST_FIRSTFAIL_EN
        check_eq("rst_ff_valid", {31'd0, ff_valid}, 32'd0);
`endif

        // Correct adder from IDLE.
        sweep(-1, 8'h00, 4'd0);

        // cout stuck at 0, launched from DONE.
        fault_mode = 1;
        sweep(-1, 8'hE8, 4'd4);
`ifdef FA_SELFTEST_FIRSTFAIL_EN
        check_eq("cout0_ff_valid", {31'd0, ff_valid}, 32'd1);
        check_eq("cout0_ff_idx", {29'd0, ff_idx}, 32'd3);
        check_eq("cout0_ff_obs", {30'd0, ff_obs}, 32'd0);
`endif

        // sum inverted; launch clears the previous failure map.
        fault_mode = 2;
        sweep(-1, 8'hFF, 4'd8);
`ifdef FA_SELFTEST_FIRSTFAIL_EN
        check_eq("suminv_ff_idx", {29'd0, ff_idx}, 32'd0);
        check_eq("suminv_ff_obs", {30'd0, ff_obs}, 32'd2);
`endif

        // Reset while vector 4 is being driven.
        fault_mode = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 13; i++) begin
            tick();
        end
        check_eq("pre_rst_abc", {29'd0, bus0.a, bus0.b, bus0.cin}, 32'd4);
        check_eq("pre_rst_err", {28'd0, err_count}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst_busy", {31'd0, busy}, 32'd0);
        check_eq("midrst_done", {31'd0, done}, 32'd0);
        check_eq("midrst_abc", {29'd0, bus0.a, bus0.b, bus0.cin}, 32'd0);
        check_eq("midrst_err", {28'd0, err_count}, 32'd0);
        check_eq("midrst_fail", {24'd0, fail_vec}, 32'd0);
        tick();
        check_eq("midrst_idle_busy", {31'd0, busy}, 32'd0);
        fault_mode = 0;
        sweep(-1, 8'h00, 4'd0);

        // start pulse while busy at vector 2 must not disturb timing.
        sweep(7, 8'h00, 4'd0);

        // SETTLE_CYCLES=1 instance: done at launch+17.
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check_eq("s1_launch_busy", {31'd0, busy1}, 32'd1);
        for (int i = 1; i <= 16; i++) begin
            tick();
        end
        check_eq("s1_done_early", {31'd0, done1}, 32'd0);
        check_eq("s1_abc_last", {29'd0, bus1.a, bus1.b, bus1.cin}, 32'd7);
        tick();
        check_eq("s1_done", {31'd0, done1}, 32'd1);
        check_eq("s1_pass", {31'd0, pass1}, 32'd1);
        check_eq("s1_err", {28'd0, err_count1}, 32'd0);
        check_eq("s1_fail", {24'd0, fail_vec1}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
